// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM for a multi-cycle RV32I datapath
// (lw, sw, R-type, I-type ALU, beq/bne, jal) sharing one ALU and one memory.
module multicycle_ctrl #(
   parameter logic [3:0] RESET_STATE = 4'd0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] Opcode,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUControl,
   output logic [1:0] ImmSrc,
   output logic       instr_done,
   output logic       illegal,
   output logic [3:0] state
);
   typedef enum logic [3:0] {
      FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3,
      MEMWB = 4'd4, MEMWRITE = 4'd5, EXECR = 4'd6, ALUWB = 4'd7,
      EXECI = 4'd8, JAL = 4'd9, BRANCH = 4'd10, TRAP = 4'd11
   } state_t;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   state_t     r_state, w_next;
   logic       r_illegal;
   logic       w_pcw, w_mw, w_irw, w_rw, w_done;
   logic [2:0] w_funct_alu;
   always_comb begin
      w_next = FETCH;
      case (r_state)
         FETCH:   w_next = DECODE;
         DECODE:  w_next = (Opcode == OP_LW || Opcode == OP_SW) ? MEMADR :
                           (Opcode == OP_R)   ? EXECR :
                           (Opcode == OP_I)   ? EXECI :
                           (Opcode == OP_JAL) ? JAL :
                           (Opcode == OP_BR)  ? BRANCH : TRAP;
         MEMADR:  w_next = (Opcode == OP_SW) ? MEMWRITE : MEMREAD;
         MEMREAD: w_next = MEMWB;
         EXECR, EXECI, JAL: w_next = ALUWB;
         TRAP:    w_next = TRAP;
         default: w_next = FETCH;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= state_t'(RESET_STATE);
         r_illegal <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_illegal <= r_illegal | (w_next == TRAP);
      end
   end
   // Unsupported funct3 values fall back to add rather than trapping
   assign w_funct_alu = (funct3 == 3'b010) ? 3'b101 :
                        (funct3 == 3'b110) ? 3'b011 :
                        (funct3 == 3'b111) ? 3'b010 :
                        (funct3 == 3'b000 && Opcode == OP_R && funct7b5) ? 3'b001 : 3'b000;
   always_comb begin
      w_pcw      = 1'b0;
      w_mw       = 1'b0;
      w_irw      = 1'b0;
      w_rw       = 1'b0;
      w_done     = 1'b0;
      AdrSrc     = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ALUControl = 3'b000;
      case (r_state)
         FETCH:    begin w_irw = 1'b1; w_pcw = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10; end
         DECODE:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; end
         MEMADR:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
         MEMREAD:  AdrSrc = 1'b1;
         MEMWRITE: begin AdrSrc = 1'b1; w_mw = 1'b1; w_done = 1'b1; end
         MEMWB:    begin ResultSrc = 2'b01; w_rw = 1'b1; w_done = 1'b1; end
         EXECR:    begin ALUSrcA = 2'b10; ALUControl = w_funct_alu; end
         EXECI:    begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; ALUControl = w_funct_alu; end
         ALUWB:    begin w_rw = 1'b1; w_done = 1'b1; end
         JAL:      begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; w_pcw = 1'b1; end
         BRANCH:   begin
            ALUSrcA    = 2'b10;
            ALUControl = 3'b001;
            w_done     = 1'b1;
            w_pcw      = (funct3 == 3'b000 && Zero) || (funct3 == 3'b001 && !Zero);
         end
         default:  ;
      endcase
   end
   // Enables are gated by reset so an abandoned instruction never writes
   assign PCWrite    = rst_n & w_pcw;
   assign MemWrite   = rst_n & w_mw;
   assign IRWrite    = rst_n & w_irw;
   assign RegWrite   = rst_n & w_rw;
   assign instr_done = rst_n & w_done;
   assign ImmSrc     = (Opcode == OP_SW)  ? 2'b01 :
                       (Opcode == OP_BR)  ? 2'b10 :
                       (Opcode == OP_JAL) ? 2'b11 : 2'b00;
   assign illegal    = r_illegal;
   assign state      = r_state;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: table vectors, reset/trap sequences and random
// instructions checked per cycle against an instruction-level model.
module tb_multicycle_ctrl;
   typedef struct packed {
      logic       pcw, adr, mw, irw, rw;
      logic [1:0] rs, sa, sb;
      logic [2:0] alu;
      logic       done;
   } ctl_t;
   typedef struct {
      logic [6:0] op;
      logic [2:0] f3;
      logic       f7, z;
      int         cyc;
      logic [1:0] imm;
      logic [2:0] alu;
      logic       pcw;
      int         dn;
   } vec_t;
   logic       clk = 1'b0, rst_n = 1'b0, funct7b5 = 1'b0, Zero = 1'b0;
   logic [6:0] Opcode = 7'd0;
   logic [2:0] funct3 = 3'd0;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, illegal;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0] ALUControl;
   logic [3:0] state;
   ctl_t       obs;
   int         n_cmp = 0, n_err = 0;
   logic       m_illegal = 1'b0;
   multicycle_ctrl dut (
      .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .funct3(funct3), .funct7b5(funct7b5),
      .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc),
      .instr_done(instr_done), .illegal(illegal), .state(state)
   );
   always #5 clk = ~clk;
   assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                 ALUSrcA, ALUSrcB, ALUControl, instr_done};
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask
   // State sequence an instruction walks through, derived from its opcode alone
   function automatic int exp_state(input logic [6:0] op, input int i);
      int p[$];
      case (op)
         7'b0000011: p = '{0, 1, 2, 3, 4};
         7'b0100011: p = '{0, 1, 2, 5};
         7'b0110011: p = '{0, 1, 6, 7};
         7'b0010011: p = '{0, 1, 8, 7};
         7'b1101111: p = '{0, 1, 9, 7};
         7'b1100011: p = '{0, 1, 10};
         default:    return (i < 2) ? i : 11;
      endcase
      return (i < p.size()) ? p[i] : 0;
   endfunction
   function automatic logic [1:0] ref_imm(input logic [6:0] op);
      return (op == 7'b0100011) ? 2'd1 : (op == 7'b1100011) ? 2'd2 :
             (op == 7'b1101111) ? 2'd3 : 2'd0;
   endfunction
   function automatic ctl_t ref_ctrl(input int s, input logic [6:0] op, input logic [2:0] f3,
                                     input logic f7, input logic z);
      ctl_t c = '0;
      logic [2:0] fd;
      fd = (f3 == 3'd2) ? 3'b101 : (f3 == 3'd6) ? 3'b011 : (f3 == 3'd7) ? 3'b010 :
           (f3 == 3'd0 && op == 7'b0110011 && f7) ? 3'b001 : 3'b000;
      case (s)
         0:  begin c.pcw = 1; c.irw = 1; c.rs = 2'b10; c.sb = 2'b10; end
         1:  begin c.sa = 2'b01; c.sb = 2'b01; end
         2:  begin c.sa = 2'b10; c.sb = 2'b01; end
         3:  c.adr = 1;
         4:  begin c.rw = 1; c.rs = 2'b01; c.done = 1; end
         5:  begin c.adr = 1; c.mw = 1; c.done = 1; end
         6:  begin c.sa = 2'b10; c.alu = fd; end
         7:  begin c.rw = 1; c.done = 1; end
         8:  begin c.sa = 2'b10; c.sb = 2'b01; c.alu = fd; end
         9:  begin c.pcw = 1; c.sa = 2'b01; c.sb = 2'b10; end
         10: begin c.sa = 2'b10; c.alu = 3'b001; c.done = 1;
                   c.pcw = (f3 == 3'd0 && z) || (f3 == 3'd1 && !z); end
         default: ;
      endcase
      return c;
   endfunction
   task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                            input logic z, input int lim, output int cyc,
                            output logic [2:0] alu_o, output logic pcw_o, output int dn,
                            output logic [1:0] imm_o);
      int es;
      Opcode = op; funct3 = f3; funct7b5 = f7; Zero = z;
      cyc = 0; alu_o = '0; pcw_o = 1'b0; dn = 0; imm_o = '0;
      do begin
         #1;
         es = exp_state(op, cyc);
         if (es == 11) m_illegal = 1'b1;
         chk("state", 32'(state), es);
         chk("ctrl", 32'(obs), 32'(ref_ctrl(es, op, f3, f7, z)));
         chk("imm", 32'(ImmSrc), 32'(ref_imm(op)));
         chk("illegal", 32'(illegal), 32'(m_illegal));
         if (state == 6 || state == 8 || state == 10) alu_o = ALUControl;
         if (state == 9 || state == 10) pcw_o = PCWrite;
         dn += int'(instr_done);
         imm_o = ImmSrc;
         @(posedge clk);
         @(negedge clk);
         cyc++;
      end while (state != 0 && cyc < lim);
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_en_low", 32'({PCWrite, IRWrite, MemWrite, RegWrite, instr_done}), 0);
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
      end
      #1;
      chk("rst_state", 32'(state), 0);
      chk("rst_illegal", 32'(illegal), 0);
      chk("rst_en_fetch", 32'({PCWrite, IRWrite, MemWrite, RegWrite, instr_done}), 0);
      m_illegal = 1'b0;
      rst_n = 1'b1;
      #1;
      chk("rel_irw", 32'(IRWrite), 1);
      chk("rel_pcw", 32'(PCWrite), 1);
      chk("rel_srcb", 32'(ALUSrcB), 2);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      vec_t       tbl[$];
      int         cyc, dn;
      logic [2:0] alu;
      logic       pcw;
      logic [1:0] imm;
      logic [6:0] ops[6] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011};
      logic [6:0] bad[4] = '{7'b0000000, 7'b0110111, 7'b1100111, 7'b1110011};
      tbl.push_back('{7'b0000011, 3'd2, 1'b0, 1'b0, 5, 2'd0, 3'b000, 1'b0, 1});
      tbl.push_back('{7'b0100011, 3'd2, 1'b0, 1'b0, 4, 2'd1, 3'b000, 1'b0, 1});
      tbl.push_back('{7'b0110011, 3'd0, 1'b1, 1'b0, 4, 2'd0, 3'b001, 1'b0, 1});
      tbl.push_back('{7'b0010011, 3'd0, 1'b1, 1'b0, 4, 2'd0, 3'b000, 1'b0, 1});
      tbl.push_back('{7'b0110011, 3'd7, 1'b0, 1'b0, 4, 2'd0, 3'b010, 1'b0, 1});
      tbl.push_back('{7'b0110011, 3'd6, 1'b0, 1'b0, 4, 2'd0, 3'b011, 1'b0, 1});
      tbl.push_back('{7'b0110011, 3'd2, 1'b0, 1'b0, 4, 2'd0, 3'b101, 1'b0, 1});
      tbl.push_back('{7'b0010011, 3'd2, 1'b0, 1'b0, 4, 2'd0, 3'b101, 1'b0, 1});
      tbl.push_back('{7'b0110011, 3'd1, 1'b0, 1'b0, 4, 2'd0, 3'b000, 1'b0, 1});
      tbl.push_back('{7'b1101111, 3'd0, 1'b0, 1'b0, 4, 2'd3, 3'b000, 1'b1, 1});
      tbl.push_back('{7'b1100011, 3'd0, 1'b0, 1'b1, 3, 2'd2, 3'b001, 1'b1, 1});
      tbl.push_back('{7'b1100011, 3'd0, 1'b0, 1'b0, 3, 2'd2, 3'b001, 1'b0, 1});
      tbl.push_back('{7'b1100011, 3'd1, 1'b0, 1'b0, 3, 2'd2, 3'b001, 1'b1, 1});
      tbl.push_back('{7'b1100011, 3'd1, 1'b0, 1'b1, 3, 2'd2, 3'b001, 1'b0, 1});
      tbl.push_back('{7'b1100011, 3'd4, 1'b0, 1'b1, 3, 2'd2, 3'b001, 1'b0, 1});
      do_reset();
      foreach (tbl[i]) begin
         run_instr(tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].z, 20, cyc, alu, pcw, dn, imm);
         chk($sformatf("v%0d_cycles", i), cyc, tbl[i].cyc);
         chk($sformatf("v%0d_imm", i), 32'(imm), 32'(tbl[i].imm));
         chk($sformatf("v%0d_alu", i), 32'(alu), 32'(tbl[i].alu));
         chk($sformatf("v%0d_pcw", i), 32'(pcw), 32'(tbl[i].pcw));
         chk($sformatf("v%0d_done", i), dn, tbl[i].dn);
      end
      // Store abandoned by reset in MEMWRITE must not write memory
      Opcode = 7'b0100011; funct3 = 3'd2; funct7b5 = 1'b0; Zero = 1'b0;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
      end
      #1;
      chk("mid_state", 32'(state), 5);
      chk("mid_memwrite", 32'(MemWrite), 1);
      do_reset();
      chk("mid_memwrite_rst", 32'(MemWrite), 0);
      // Illegal opcode: trap holds with all enables low until reset
      run_instr(7'b0000000, 3'd0, 1'b0, 1'b0, 14, cyc, alu, pcw, dn, imm);
      chk("trap_cycles", cyc, 14);
      chk("trap_done", dn, 0);
      #1;
      chk("trap_stuck", 32'(state), 11);
      chk("trap_illegal", 32'(illegal), 1);
      do_reset();
      for (int n = 0; n < 150; n++) begin
         int k;
         k = $urandom_range(0, 6);
         if (k == 6) begin
            run_instr(bad[$urandom_range(0, 3)], 3'($urandom), 1'($urandom), 1'($urandom),
                      5, cyc, alu, pcw, dn, imm);
            do_reset();
         end else begin
            run_instr(ops[k], 3'($urandom), 1'($urandom), 1'($urandom), 20, cyc, alu, pcw, dn, imm);
            chk("rnd_done", dn, 1);
         end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle RV32I datapath (subset: lw, sw, R-type, I-type ALU, beq/bne, jal).
- Sequences the shared ALU, the unified instruction/data memory and the register file.
- Drives ImmSrc to the immediate generator: I-format for loads and I-ALU, S-format for stores, B-format for branches, J-format for jal.
- Sits between the instruction register (Opcode/funct fields) and the datapath mux selects and enables.

Parameters:
- RESET_STATE, 4'd0, state entered on reset (FETCH); must be a valid state encoding.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active low
- Opcode  input  7  instruction[6:0] from IR
- funct3  input  3  instruction[14:12]
- funct7b5  input  1  instruction[30]
- Zero  input  1  ALU zero flag, valid in BRANCH state
- PCWrite  output  1  PC register enable
- AdrSrc  output  1  memory address select: 0=PC, 1=ALUOut
- MemWrite  output  1  memory write enable
- IRWrite  output  1  IR/OldPC enable
- RegWrite  output  1  register file write enable
- ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  output  2  00=PC, 01=OldPC, 10=rs1 data
- ALUSrcB  output  2  00=rs2 data, 01=ImmExt, 10=constant 4
- ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- ImmSrc  output  2  00=I, 01=S, 10=B, 11=J
- instr_done  output  1  one-cycle pulse when an instruction retires
- illegal  output  1  sticky; unsupported opcode decoded
- state  output  4  current state, for debug

Behaviour:
- State register updates on rising clk. rst_n=0 at an edge -> state=FETCH and illegal=0.
- While rst_n=0, all enables (PCWrite, IRWrite, MemWrite, RegWrite, instr_done) are forced 0 combinationally. Reset mid-instruction abandons it with no partial write.
- States: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BRANCH=10, TRAP=11. Codes 12-15 -> FETCH on the next edge.
- Transitions:
  - FETCH->DECODE.
  - DECODE: lw/sw->MEMADR; 0110011->EXECR; 0010011->EXECI; 1101111->JAL; 1100011->BRANCH; any other opcode->TRAP.
  - MEMADR: lw->MEMREAD, sw->MEMWRITE.
  - MEMREAD->MEMWB.
  - EXECR, EXECI, JAL->ALUWB.
  - MEMWB, ALUWB, MEMWRITE, BRANCH->FETCH.
  - TRAP->TRAP until reset.
- Per-state outputs (unlisted outputs are 0; ALUOp defaults to add):
  - FETCH: AdrSrc=0, IRWrite=1, SrcA=00, SrcB=10, add, ResultSrc=10, PCWrite=1.
  - DECODE: SrcA=01, SrcB=01, add (branch/jump target into ALUOut).
  - MEMADR: SrcA=10, SrcB=01, add.
  - MEMREAD: ResultSrc=00, AdrSrc=1.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - EXECR: SrcA=10, SrcB=00, funct-decoded.
  - EXECI: SrcA=10, SrcB=01, funct-decoded.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - JAL: SrcA=01, SrcB=10, add, ResultSrc=00, PCWrite=1.
  - BRANCH: SrcA=10, SrcB=00, sub, ResultSrc=00. PCWrite = (funct3==000 & Zero) | (funct3==001 & !Zero).
  - TRAP: illegal=1, all enables 0.
- Funct decode:
  - funct3 000: sub only if Opcode=0110011 and funct7b5=1, else add.
  - 010->slt; 110->or; 111->and.
  - Other funct3 values -> add; the instruction is not flagged illegal.
- ImmSrc is combinational from Opcode in every state: 0000011/0010011->00, 0100011->01, 1100011->10, 1101111->11, other->00.
- instr_done=1 for the single cycle in MEMWB, ALUWB, MEMWRITE or BRANCH.
- Cycle counts from FETCH to FETCH: lw 5, R/I/jal 4, sw 4, branch 3.

Test Plan:
- Reset: hold rst_n=0 for 2 edges in any state -> state=0, all enables 0 while low. After release, first cycle shows IRWrite=1, PCWrite=1, ALUSrcB=10.
- lw (Opcode 0000011) -> states 0,1,2,3,4. ImmSrc=00 throughout. RegWrite=1 with ResultSrc=01 only in state 4. instr_done is a single pulse.
- sw (0100011) -> states 0,1,2,5. MemWrite=1, AdrSrc=1 only in state 5. ImmSrc=01. RegWrite never 1.
- R-type sub (0110011, funct3 000, funct7b5=1) -> ALUControl=001 in EXECR. Same fields with Opcode 0010011 -> 000. funct3 111 -> 010.
- Branch: beq Zero=1 -> PCWrite=1 in BRANCH. beq Zero=0 -> 0. bne Zero=0 -> 1. ImmSrc=10. Back to FETCH in 3 cycles.
- Illegal opcode 0000000 -> TRAP. illegal=1 and all enables 0 for 10+ cycles. Only rst_n=0 exits to FETCH.
